uart_tx_buffered: RTL

// - Buffered UART transmitter: accepts bytes over a valid/ready write port into an internal FIFO, serialises them LSB-first, 8N1.
// - Transmit-side counterpart of the RX path; line format and `mode` baud table match the RX module, so `tx_line` can drive an RX instance directly.
// - Sits between a byte producer (CORE, loopback FIFO) and the board `tx` pin. Absorbs bursts without a separate FIFO.

---
 rtl/uart_tx_buffered.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffered.sv
// Purpose  : buffered 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined), LSB first.
// Latency  : byte accepted at edge N into an empty FIFO with the line idle leaves as a start bit from edge N+1.
// Backpress: data_ready = !full; a pop in the same cycle never frees a slot for a write while full.
//
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit between data bit 7 and stop).
//
// Ports (uart_tx_buffered):
//   clk, rst_n          system clock (rising edge), async active-low reset
//   data_in/data_valid  write port, byte accepted when data_valid && data_ready
//   data_ready          FIFO not full
//   mode                baud select: 0=9600, 1=115200, 2=57600, 3=19200, others=115200
//   tx_line             registered serial output, idle high
//   busy                frame in progress or bytes still queued
//   fifo_count          bytes waiting in the FIFO (not counting the one being shifted)

// Purpose  : generic single-clock FIFO, first-word fall-through read.
// Latency  : pushed word visible on pop_dat the cycle after the push edge.
// Backpress: push ignored when full, pop ignored when empty; count has one extra bit for full/empty.
//
// Ports: push/push_dat write side, pop/pop_dat read side, full/empty/count status.
module sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_dat,
  input  logic                     pop,
  output logic [DW-1:0]            pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// Purpose  : buffered UART transmitter, FIFO in front of a start/data/[parity]/stop serialiser.
// Latency  : start bit from the edge after the first byte lands in an empty FIFO; frames back-to-back.
// Backpress: data_ready drops only when the FIFO is full; held writes wait, nothing is dropped.
module uart_tx_buffered #(
  parameter int CLK_FREQ   = 50000000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  input  logic [3:0]                    mode,
  output logic                          tx_line,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int DIV_9600   = CLK_FREQ / 9600;
  localparam int DIV_19200  = CLK_FREQ / 19200;
  localparam int DIV_57600  = CLK_FREQ / 57600;
  localparam int DIV_115200 = CLK_FREQ / 115200;
  // The slowest baud gives the largest divisor.
  localparam int CNT_W      = $clog2(DIV_9600 + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;

  logic [CNT_W-1:0]   div_sel;
  logic [CNT_W-1:0]   div_m1;
  logic [CNT_W-1:0]   cnt_dec;
  logic               bit_last;
  logic               fifo_pop;
  logic [7:0]         fifo_dat;
  logic               fifo_full;
  logic               fifo_empty;

  sync_fifo #(
    .DW    (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (data_valid),
    .push_dat (data_in),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign data_ready = !fifo_full;
  assign tx_line    = tx_q;
  assign busy       = (state_q != ST_IDLE) || (fifo_count != '0);

  always_comb begin
    case (mode)
      4'd0:    div_sel = CNT_W'(DIV_9600);
      4'd2:    div_sel = CNT_W'(DIV_57600);
      4'd3:    div_sel = CNT_W'(DIV_19200);
      default: div_sel = CNT_W'(DIV_115200);
    endcase
  end

  assign div_m1   = div_q - CNT_W'(1);
  assign cnt_dec  = cnt_q - CNT_W'(1);
  assign bit_last = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
      end
      ST_START: begin
        if (bit_last) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          cnt_d     = div_m1;
          tx_d      = shift_q[0];
        end else begin
          cnt_d = cnt_dec;
        end
      end
      ST_DATA: begin
        if (bit_last) begin
          cnt_d = div_m1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = ^shift_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[bit_idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_dec;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_last) begin
          state_d = ST_STOP;
          cnt_d   = div_m1;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
`endif
      ST_STOP: begin
        if (bit_last) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Frame start from IDLE or straight out of the last stop cycle, so queued
    // bytes follow each other with no idle gap. mode is sampled only here.
    if (((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_last)) && !fifo_empty) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_dat;
      div_d    = div_sel;
      cnt_d    = div_sel - CNT_W'(1);
      tx_d     = 1'b0;
      state_d  = ST_START;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end
endmodule
